// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - shared match-sequencer types and constants
package fighter_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    INTRO      = 3'd1,
    FIGHT      = 3'd2,
    ROUND_OVER = 3'd3,
    MATCH_OVER = 3'd4
  } game_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    RYU   = 2'b01,
    AKUMA = 2'b10,
    DRAW  = 2'b11
  } winner_t;

  localparam logic [7:0] HEALTH_FULL = 8'd100;
  localparam logic [1:0] TALLY_MAX   = 2'd3;

  // Larger value wins; used for both health at time-out and win tallies.
  function automatic winner_t higher(input logic [7:0] ryu, input logic [7:0] akuma);
    if (ryu > akuma)      return RYU;
    else if (akuma > ryu) return AKUMA;
    else                  return DRAW;
  endfunction

endpackage

// File: rtl/round_timer.sv
// rtl/round_timer.sv - frame counter plus round seconds down-counter
module round_timer #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int ROUND_SECS     = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       enable,
  output logic [6:0] secs,
  output logic       expire
);

  localparam int FW = $clog2(FRAMES_PER_SEC + 1);

  logic [FW-1:0] frame_cnt;
  logic          wrap;

  assign wrap   = (frame_cnt == FW'(FRAMES_PER_SEC - 1));
  // Combinational so the controller leaves FIGHT on the edge that zeroes secs.
  assign expire = enable && wrap && (secs == 7'd1);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      frame_cnt <= '0;
      secs      <= 7'(ROUND_SECS);
    end else if (enable) begin
      if (wrap) begin
        frame_cnt <= '0;
        if (secs != 7'd0) secs <= secs - 7'd1;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

endmodule

// File: rtl/round_controller.sv
// rtl/round_controller.sv - match sequencer: phases, round timer, tallies, winners
module round_controller
  import fighter_pkg::*;
#(
  parameter int FRAMES_PER_SEC = 60,
  parameter int ROUND_SECS     = 99,
  parameter int INTRO_FRAMES   = 120,
  parameter int OVER_FRAMES    = 180,
  parameter int WINS_TO_MATCH  = 2,
  parameter int MAX_ROUNDS     = 5
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        start_key,
  input  logic [7:0]  ryu_health,
  input  logic [7:0]  akuma_health,
  output logic        fight_en,
  output logic        health_rst,
  output game_state_t game_state,
  output logic [6:0]  timer_secs,
  output logic [2:0]  round_num,
  output logic [1:0]  ryu_wins,
  output logic [1:0]  akuma_wins,
  output winner_t     round_winner,
  output winner_t     match_winner
);

  localparam int HOLD_W = 16;

  game_state_t       state_n;
  winner_t           win_n;
  logic              round_end, enter_intro, expire, start_q, start_evt;
  logic [HOLD_W-1:0] hold_cnt;

  assign start_evt = start_key && !start_q;

  round_timer #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC),
    .ROUND_SECS    (ROUND_SECS)
  ) u_timer (
    .clk   (frame_clk),
    .reset (Reset),
    .load  (enter_intro),
    .enable(game_state == FIGHT),
    .secs  (timer_secs),
    .expire(expire)
  );

  always_comb begin
    state_n   = game_state;
    win_n     = NONE;
    round_end = 1'b0;
    case (game_state)
      IDLE:  if (start_evt) state_n = INTRO;
      INTRO: if (hold_cnt == HOLD_W'(INTRO_FRAMES - 1)) state_n = FIGHT;
      FIGHT: begin
        // KO outranks a time-out landing on the same cycle.
        if (ryu_health == 8'd0 && akuma_health == 8'd0) win_n = DRAW;
        else if (akuma_health == 8'd0)                  win_n = RYU;
        else if (ryu_health == 8'd0)                    win_n = AKUMA;
        else if (expire)                                win_n = higher(ryu_health, akuma_health);
        round_end = (win_n != NONE);
        if (round_end) state_n = ROUND_OVER;
      end
      ROUND_OVER: begin
        if (hold_cnt == HOLD_W'(OVER_FRAMES - 1)) begin
          if (ryu_wins == 2'(WINS_TO_MATCH) || akuma_wins == 2'(WINS_TO_MATCH) ||
              round_num == 3'(MAX_ROUNDS))
            state_n = MATCH_OVER;
          else
            state_n = INTRO;
        end
      end
      MATCH_OVER: if (start_evt) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
    enter_intro = (state_n == INTRO) && (game_state != INTRO);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      game_state   <= IDLE;
      start_q      <= 1'b1;
      hold_cnt     <= '0;
      fight_en     <= 1'b0;
      health_rst   <= 1'b0;
      round_num    <= 3'd0;
      ryu_wins     <= 2'd0;
      akuma_wins   <= 2'd0;
      round_winner <= NONE;
      match_winner <= NONE;
    end else begin
      game_state <= state_n;
      start_q    <= start_key;
      fight_en   <= (state_n == FIGHT);
      health_rst <= enter_intro;
      if (state_n != game_state)
        hold_cnt <= '0;
      else if (game_state == INTRO || game_state == ROUND_OVER)
        hold_cnt <= hold_cnt + HOLD_W'(1);
      if (enter_intro) round_num <= round_num + 3'd1;
      if (round_end) begin
        round_winner <= win_n;
        if (win_n == RYU && ryu_wins != TALLY_MAX)     ryu_wins   <= ryu_wins + 2'd1;
        if (win_n == AKUMA && akuma_wins != TALLY_MAX) akuma_wins <= akuma_wins + 2'd1;
      end
      if (game_state == ROUND_OVER && state_n == MATCH_OVER)
        match_winner <= higher({6'd0, ryu_wins}, {6'd0, akuma_wins});
      if (game_state == MATCH_OVER && state_n == IDLE) begin
        round_num    <= 3'd0;
        ryu_wins     <= 2'd0;
        akuma_wins   <= 2'd0;
        round_winner <= NONE;
        match_winner <= NONE;
      end
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// tb/tb_round_controller.sv - self-checking bench for round_controller
module tb_round_controller;
  import fighter_pkg::*;

  localparam int FPS = 4;
  localparam int RS  = 3;
  localparam int IF  = 2;
  localparam int OF  = 2;
  localparam int WM  = 2;
  localparam int MR  = 5;
  localparam int HF  = int'(HEALTH_FULL);

  logic        clk, rst, start_key;
  logic [7:0]  ryu_h, akuma_h;
  logic        fight_en, health_rst;
  game_state_t game_state;
  logic [6:0]  timer_secs;
  logic [2:0]  round_num;
  logic [1:0]  ryu_wins, akuma_wins;
  winner_t     round_winner, match_winner;

  int n_checks = 0;
  int n_pass   = 0;

  round_controller #(
    .FRAMES_PER_SEC(FPS), .ROUND_SECS(RS), .INTRO_FRAMES(IF),
    .OVER_FRAMES(OF), .WINS_TO_MATCH(WM), .MAX_ROUNDS(MR)
  ) dut (
    .frame_clk   (clk),
    .Reset       (rst),
    .start_key   (start_key),
    .ryu_health  (ryu_h),
    .akuma_health(akuma_h),
    .fight_en    (fight_en),
    .health_rst  (health_rst),
    .game_state  (game_state),
    .timer_secs  (timer_secs),
    .round_num   (round_num),
    .ryu_wins    (ryu_wins),
    .akuma_wins  (akuma_wins),
    .round_winner(round_winner),
    .match_winner(match_winner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
  endtask

  // Reference model: phase plus age in phase, seconds derived from elapsed fight cycles.
  bit          m_valid = 1'b0;
  bit          m_prev, start_ev;
  game_state_t m_state, nx;
  winner_t     m_rwin, m_mwin, w;
  int          m_age, m_k, m_secs, m_round, m_rw, m_aw;
  bit          m_hrst;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1; m_state = IDLE; m_age = 0; m_k = 0; m_secs = RS;
      m_round = 0; m_rw = 0; m_aw = 0; m_rwin = NONE; m_mwin = NONE;
      m_hrst = 1'b0; m_prev = 1'b1;
    end else if (m_valid) begin
      start_ev = start_key && !m_prev;
      m_prev   = start_key;
      nx       = m_state;
      m_hrst   = 1'b0;
      case (m_state)
        IDLE: if (start_ev) begin
          nx = INTRO; m_round = 1; m_hrst = 1'b1; m_secs = RS;
        end
        INTRO: if (m_age + 1 == IF) begin
          nx = FIGHT; m_k = 0;
        end
        FIGHT: begin
          m_k++;
          m_secs = RS - m_k / FPS;
          w = NONE;
          if (ryu_h == 0 || akuma_h == 0)
            w = (ryu_h == 0 && akuma_h == 0) ? DRAW : ((akuma_h == 0) ? RYU : AKUMA);
          else if (m_k == RS * FPS)
            w = (ryu_h > akuma_h) ? RYU : ((ryu_h < akuma_h) ? AKUMA : DRAW);
          if (w != NONE) begin
            m_rwin = w;
            if (w == RYU && m_rw < 3)   m_rw++;
            if (w == AKUMA && m_aw < 3) m_aw++;
            nx = ROUND_OVER;
          end
        end
        ROUND_OVER: if (m_age + 1 == OF) begin
          if (m_rw == WM || m_aw == WM || m_round == MR) begin
            nx = MATCH_OVER;
            m_mwin = (m_rw > m_aw) ? RYU : ((m_rw < m_aw) ? AKUMA : DRAW);
          end else begin
            nx = INTRO; m_round++; m_hrst = 1'b1; m_secs = RS;
          end
        end
        MATCH_OVER: if (start_ev) begin
          nx = IDLE; m_round = 0; m_rw = 0; m_aw = 0; m_rwin = NONE; m_mwin = NONE;
        end
        default: nx = IDLE;
      endcase
      m_age   = (nx == m_state) ? m_age + 1 : 0;
      m_state = nx;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("game_state",   int'(game_state),   int'(m_state));
      check("fight_en",     int'(fight_en),     int'(m_state == FIGHT));
      check("health_rst",   int'(health_rst),   int'(m_hrst));
      check("timer_secs",   int'(timer_secs),   m_secs);
      check("round_num",    int'(round_num),    m_round);
      check("ryu_wins",     int'(ryu_wins),     m_rw);
      check("akuma_wins",   int'(akuma_wins),   m_aw);
      check("round_winner", int'(round_winner), int'(m_rwin));
      check("match_winner", int'(match_winner), int'(m_mwin));
    end
  end

  task automatic cyc(input logic r, input logic sk, input int rh, input int ah);
    rst = r; start_key = sk; ryu_h = 8'(rh); akuma_h = 8'(ah);
    @(negedge clk);
  endtask

  task automatic run_until(input game_state_t s, input int rh, input int ah);
    int n = 0;
    while (game_state != s && n < 200) begin
      cyc(1'b0, 1'b0, rh, ah);
      n++;
    end
    check("reach_state", int'(game_state), int'(s));
  endtask

  task automatic fight_loop(input int rh, input int ah, output int n);
    n = 0;
    while (game_state == FIGHT && n < 100) begin
      cyc(1'b0, 1'b0, rh, ah);
      n++;
    end
  endtask

  initial begin
    int   n;
    logic sk;
    int   rh, ah;

    // Key held through reset must not start a match.
    cyc(1, 1, HF, HF);
    cyc(1, 1, HF, HF);
    check("lit_reset_state", int'(game_state), int'(IDLE));
    check("lit_reset_secs",  int'(timer_secs), 3);
    repeat (3) cyc(0, 1, HF, HF);
    check("lit_held_key_idle", int'(game_state), int'(IDLE));
    cyc(0, 0, HF, HF);
    cyc(0, 1, HF, HF);
    check("lit_intro",       int'(game_state), int'(INTRO));
    check("lit_intro_hrst",  int'(health_rst), 1);
    check("lit_intro_round", int'(round_num),  1);
    cyc(0, 1, HF, HF);
    check("lit_hrst_one_cycle", int'(health_rst), 0);
    cyc(0, 1, HF, HF);
    check("lit_fight_after_2", int'(game_state), int'(FIGHT));
    check("lit_fight_en",      int'(fight_en),   1);

    // Akuma KO.
    cyc(0, 0, HF, 0);
    check("lit_ko_state",    int'(game_state),   int'(ROUND_OVER));
    check("lit_ko_winner",   int'(round_winner), int'(RYU));
    check("lit_ko_ryu_wins", int'(ryu_wins),     1);
    check("lit_ko_fight_en", int'(fight_en),     0);

    // Time-out 50/30 wins round 2 and the match for Ryu.
    run_until(FIGHT, HF, HF);
    fight_loop(50, 30, n);
    check("lit_timeout_cycles", n, 12);
    check("lit_timeout_winner", int'(round_winner), int'(RYU));
    check("lit_timeout_secs",   int'(timer_secs),   0);
    run_until(MATCH_OVER, HF, HF);
    check("lit_match_ryu", int'(match_winner), int'(RYU));
    cyc(0, 1, HF, HF);
    check("lit_back_idle",      int'(game_state), int'(IDLE));
    check("lit_idle_tally",     int'(ryu_wins),   0);
    check("lit_idle_round_num", int'(round_num),  0);

    // Equal-health time-out, then KO on the expiry cycle, then draws to the round cap.
    cyc(0, 0, HF, HF);
    cyc(0, 1, HF, HF);
    run_until(FIGHT, HF, HF);
    fight_loop(40, 40, n);
    check("lit_draw_cycles", n, 12);
    check("lit_draw_winner", int'(round_winner), int'(DRAW));
    check("lit_draw_tally",  int'(ryu_wins) + int'(akuma_wins), 0);
    run_until(FIGHT, HF, HF);
    repeat (11) cyc(0, 0, 60, 60);
    cyc(0, 0, 0, 0);
    check("lit_ko_prio_state",  int'(game_state),   int'(ROUND_OVER));
    check("lit_ko_prio_winner", int'(round_winner), int'(DRAW));
    repeat (3) begin
      run_until(FIGHT, HF, HF);
      cyc(0, 0, 0, 0);
    end
    run_until(MATCH_OVER, HF, HF);
    check("lit_cap_round",  int'(round_num),    5);
    check("lit_cap_winner", int'(match_winner), int'(DRAW));

    // Reset mid-fight.
    cyc(0, 1, HF, HF);
    cyc(0, 0, HF, HF);
    cyc(0, 1, HF, HF);
    run_until(FIGHT, HF, HF);
    repeat (4) cyc(0, 0, HF, HF);
    check("lit_mid_secs", int'(timer_secs), 2);
    cyc(1, 0, HF, HF);
    check("lit_rst_state", int'(game_state), int'(IDLE));
    check("lit_rst_secs",  int'(timer_secs), 3);
    check("lit_rst_fight", int'(fight_en),   0);
    check("lit_rst_hrst",  int'(health_rst), 0);
    cyc(0, 0, HF, HF);

    // Randomised traffic checked by the model each cycle.
    sk = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) sk = ~sk;
      rh = ($urandom_range(0, 29) == 0) ? 0 : int'($urandom_range(1, 255));
      ah = ($urandom_range(0, 29) == 0) ? 0 : int'($urandom_range(1, 255));
      if ($urandom_range(0, 9) == 0) ah = rh;
      cyc(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, sk, rh, ah);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
